// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing (pixel phase, counters, blank) with delayed syncs,
// a frame-start pulse and a free-running frame counter.
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int PIPE_DELAY = 2
) (
  input  logic        Clk,
  input  logic        Reset_n,
  output logic        vga_clk,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        frame_clk,
  output logic        frame_start,
  output logic [15:0] frame_count
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0] H_MAX = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS = 10'(V_VISIBLE);
  localparam logic [9:0] HS_LO = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_HI = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_LO = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_HI = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  logic       ph, pix_ce, h_wrap, f_wrap, hs_raw, vs_raw, vs_raw_next;
  logic [9:0] hc, vc, hc_next, vc_next;
  assign pix_ce  = ph;
  assign vga_clk = ph;
  assign DrawX   = hc;
  assign DrawY   = vc;
  always_comb begin
    h_wrap      = pix_ce && (hc == H_MAX);
    f_wrap      = h_wrap && (vc == V_MAX);
    hc_next     = !pix_ce ? hc : h_wrap ? '0 : hc + 10'd1;
    vc_next     = !h_wrap ? vc : (vc == V_MAX) ? '0 : vc + 10'd1;
    blank       = (hc < H_VIS) && (vc < V_VIS);
    hs_raw      = !((hc >= HS_LO) && (hc < HS_HI));
    vs_raw      = !((vc >= VS_LO) && (vc < VS_HI));
    vs_raw_next = !((vc_next >= VS_LO) && (vc_next < VS_HI));
  end
  // frame_clk is loaded from the counters being written, so it equals ~vs_raw outside reset
  always_ff @(posedge Clk)
    if (!Reset_n) begin
      ph          <= 1'b0;
      hc          <= '0;
      vc          <= '0;
      frame_clk   <= 1'b1;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      ph          <= ~ph;
      hc          <= hc_next;
      vc          <= vc_next;
      frame_clk   <= ~vs_raw_next;
      frame_start <= f_wrap;
      frame_count <= frame_count + 16'(f_wrap);
    end
  generate
    if (PIPE_DELAY == 0) begin : g_nodly
      assign hs = hs_raw;
      assign vs = vs_raw;
    end else begin : g_dly
      logic [PIPE_DELAY-1:0] hs_d, vs_d;
      always_ff @(posedge Clk)
        if (!Reset_n) begin
          hs_d <= '1;
          vs_d <= '1;
        end else if (pix_ce) begin
          hs_d <= (hs_d << 1) | PIPE_DELAY'(hs_raw);
          vs_d <= (vs_d << 1) | PIPE_DELAY'(vs_raw);
        end
      assign hs = hs_d[PIPE_DELAY-1];
      assign vs = vs_d[PIPE_DELAY-1];
    end
  endgenerate
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: vector table, corner sequences and a per-cycle arithmetic raster model
module tb_vga_timing_gen;
  logic Clk = 1'b0;
  always #5 Clk = ~Clk;
  logic        rn_a, rn_b, rn_c;
  logic        ck_a, bl_a, hs_a, vs_a, fk_a, fs_a;
  logic        ck_b, bl_b, hs_b, vs_b, fk_b, fs_b;
  logic        ck_c, bl_c, hs_c, vs_c, fk_c, fs_c;
  logic [9:0]  x_a, y_a, x_b, y_b, x_c, y_c;
  logic [15:0] fc_a, fc_b, fc_c;
  logic [41:0] got_a, got_b, got_c;
  int tests = 0, fails = 0, cyc = 0;
  int na = 0, nb = 0, nc = 0;
  bit ok_a = 0, ok_b = 0, ok_c = 0;
  vga_timing_gen dut_a (.Clk(Clk), .Reset_n(rn_a), .vga_clk(ck_a), .DrawX(x_a), .DrawY(y_a),
    .blank(bl_a), .hs(hs_a), .vs(vs_a), .frame_clk(fk_a), .frame_start(fs_a), .frame_count(fc_a));
  vga_timing_gen #(.PIPE_DELAY(0)) dut_b (.Clk(Clk), .Reset_n(rn_b), .vga_clk(ck_b), .DrawX(x_b),
    .DrawY(y_b), .blank(bl_b), .hs(hs_b), .vs(vs_b), .frame_clk(fk_b), .frame_start(fs_b),
    .frame_count(fc_b));
  vga_timing_gen #(.H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1), .V_VISIBLE(1), .V_FRONT(1),
    .V_SYNC(1), .V_BACK(1), .PIPE_DELAY(2)) dut_c (.Clk(Clk), .Reset_n(rn_c), .vga_clk(ck_c),
    .DrawX(x_c), .DrawY(y_c), .blank(bl_c), .hs(hs_c), .vs(vs_c), .frame_clk(fk_c),
    .frame_start(fs_c), .frame_count(fc_c));
  assign got_a = {ck_a, x_a, y_a, bl_a, hs_a, vs_a, fk_a, fs_a, fc_a};
  assign got_b = {ck_b, x_b, y_b, bl_b, hs_b, vs_b, fk_b, fs_b, fc_b};
  assign got_c = {ck_c, x_c, y_c, bl_c, hs_c, vs_c, fk_c, fs_c, fc_c};
  // Outputs after n Clk edges since the last reset edge, from raster position arithmetic
  function automatic logic [41:0] exp_out(int n, int hv, int hf, int hw, int hb, int vv, int vf,
                                          int vw, int vb, int pd);
    int ht = hv + hf + hw + hb;
    int vt = vv + vf + vw + vb;
    int k = n / 2;
    int hx = k % ht;
    int vy = (k / ht) % vt;
    int f = ht * vt;
    int kd = k - pd;
    logic h, v, fk, fs, bl;
    h = 1'b1;
    v = 1'b1;
    if (kd >= 0) begin
      h = !((kd % ht) >= hv + hf && (kd % ht) < hv + hf + hw);
      v = !(((kd / ht) % vt) >= vv + vf && ((kd / ht) % vt) < vv + vf + vw);
    end
    fk = (n == 0) ? 1'b1 : (vy >= vv + vf && vy < vv + vf + vw);
    fs = (n % 2 == 0) && (k > 0) && (k % f == 0);
    bl = (hx < hv) && (vy < vv);
    return {1'(n % 2), 10'(hx), 10'(vy), bl, h, v, fk, fs, 16'(k / f)};
  endfunction
  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
    end
  endtask
  task automatic step();
    @(posedge Clk);
    cyc++;
    na = rn_a ? na + 1 : 0;
    nb = rn_b ? nb + 1 : 0;
    nc = rn_c ? nc + 1 : 0;
    ok_a |= !rn_a;
    ok_b |= !rn_b;
    ok_c |= !rn_c;
    #1;
    if (ok_a) chk("model_a", got_a, exp_out(na, 640, 16, 96, 48, 480, 10, 2, 33, 2));
    if (ok_b) chk("model_b", got_b, exp_out(nb, 640, 16, 96, 48, 480, 10, 2, 33, 0));
    if (ok_c) chk("model_c", got_c, exp_out(nc, 4, 1, 2, 1, 1, 1, 1, 1, 2));
  endtask
  typedef struct {
    int         n;
    logic       ck;
    logic [9:0] x, y;
    logic       bl, ha, hb, va;
  } vec_t;
  vec_t tbl[16];
  initial begin
    int ti, t0, t1, t2;
    bit found;
    logic prev;
    tbl[0]  = '{1,    1'b1, 10'd0,   10'd0, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[1]  = '{2,    1'b0, 10'd1,   10'd0, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[2]  = '{4,    1'b0, 10'd2,   10'd0, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[3]  = '{1278, 1'b0, 10'd639, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[4]  = '{1280, 1'b0, 10'd640, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[5]  = '{1312, 1'b0, 10'd656, 10'd0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{1314, 1'b0, 10'd657, 10'd0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{1316, 1'b0, 10'd658, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1502, 1'b0, 10'd751, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1504, 1'b0, 10'd752, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{1506, 1'b0, 10'd753, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[11] = '{1508, 1'b0, 10'd754, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[12] = '{1598, 1'b0, 10'd799, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[13] = '{1599, 1'b1, 10'd799, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[14] = '{1600, 1'b0, 10'd0,   10'd1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[15] = '{2916, 1'b0, 10'd658, 10'd1, 1'b0, 1'b0, 1'b0, 1'b1};
    rn_a = 1'b0;
    rn_b = 1'b0;
    rn_c = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_a", got_a, {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'd0});
    end
    rn_a = 1'b1;
    rn_b = 1'b1;
    rn_c = 1'b1;
    ti = 0;
    for (int n = 1; n <= 2920; n++) begin
      step();
      if (ti < 16 && tbl[ti].n == n) begin
        chk("vec", {ck_a, x_a, y_a, bl_a, hs_a, hs_b, vs_a},
            {tbl[ti].ck, tbl[ti].x, tbl[ti].y, tbl[ti].bl, tbl[ti].ha, tbl[ti].hb, tbl[ti].va});
        ti++;
      end
    end
    chk("vec_all_seen", 64'(ti), 64'd16);
    // small instance: frame_clk rise, frame_start period and width
    rn_c = 1'b0;
    step();
    rn_c = 1'b1;
    t0 = cyc;
    found = 0;
    prev = fk_c;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      if (y_c == 10'd2) begin
        found = 1;
        chk("fclk_rise", {prev, fk_c}, 2'b01);
      end
      prev = fk_c;
    end
    chk("fclk_wait", 64'(found), 64'd1);
    found = 0;
    t1 = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (fs_c) begin
        found = 1;
        t1 = cyc;
      end
    end
    chk("fs_first", 64'(t1 - t0), 64'd64);
    chk("fcnt_1", fc_c, 16'd1);
    step();
    chk("fs_width", fs_c, 1'b0);
    found = 0;
    t2 = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (fs_c) begin
        found = 1;
        t2 = cyc;
      end
    end
    chk("fs_period", 64'(t2 - t1), 64'd64);
    chk("fcnt_2", fc_c, 16'd2);
    // mid-frame reset while vs is low
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      found = (y_c == 10'd2) && (x_c == 10'd5) && (vs_c == 1'b0);
    end
    chk("vs_low_wait", 64'(found), 64'd1);
    rn_c = 1'b0;
    step();
    chk("midreset", {x_c, y_c, hs_c, vs_c, fk_c, fc_c},
        {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 16'd0});
    rn_c = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("no_residual_sync", {hs_c, vs_c}, 2'b11);
    end
    // randomized reset pulses, every cycle checked against the model
    for (int i = 0; i < 15000; i++) begin
      rn_a = ($urandom_range(0, 2999) != 0);
      rn_b = ($urandom_range(0, 2999) != 0);
      rn_c = ($urandom_range(0, 399) != 0);
      step();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
